// File: rtl/alu_exec_if.sv
// Dispatch port from the reservation station plus the ALU common-data-bus broadcast.
// master = RS/consumer side, slave = execute unit.
interface alu_exec_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6
);
    logic              in_rs_enable;
    logic [OP_W-1:0]   in_rs_type;
    logic [ADDR_W-1:0] in_rs_pc;
    logic [DATA_W-1:0] in_rs_imm;
    logic [DATA_W-1:0] in_rs_left_oprand;
    logic [DATA_W-1:0] in_rs_right_oprand;
    logic [ROB_W-1:0]  in_rs_dest;

    logic              out_broadcast_enable;
    logic [ROB_W-1:0]  out_broadcast_reorder;
    logic [DATA_W-1:0] out_broadcast_result;
    logic              out_broadcast_is_jump;
    logic              out_broadcast_taken;
    logic [ADDR_W-1:0] out_broadcast_target_pc;

    modport master (
        output in_rs_enable, in_rs_type, in_rs_pc, in_rs_imm,
               in_rs_left_oprand, in_rs_right_oprand, in_rs_dest,
        input  out_broadcast_enable, out_broadcast_reorder, out_broadcast_result,
               out_broadcast_is_jump, out_broadcast_taken, out_broadcast_target_pc
    );

    modport slave (
        input  in_rs_enable, in_rs_type, in_rs_pc, in_rs_imm,
               in_rs_left_oprand, in_rs_right_oprand, in_rs_dest,
        output out_broadcast_enable, out_broadcast_reorder, out_broadcast_result,
               out_broadcast_is_jump, out_broadcast_taken, out_broadcast_target_pc
    );
endinterface

// File: rtl/alu_exec.sv
// Single-cycle RV32I integer execute unit: computes ALU/branch/jump results for
// one dispatched op per ready cycle and drives the ALU CDB broadcast one cycle later.
module alu_exec #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6
) (
    input  logic     in_clk,
    input  logic     in_rst,
    input  logic     in_rdy,
    input  logic     in_rob_clear,
    alu_exec_if.slave port_if
);
    // Operator codes shared with the decoder; loads/stores never reach this unit.
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

    logic              enable_reg;
    logic [ROB_W-1:0]  reorder_reg;
    logic [DATA_W-1:0] result_reg;
    logic              is_jump_reg;
    logic              taken_reg;
    logic [ADDR_W-1:0] target_reg;

    logic [DATA_W-1:0] result_next;
    logic              is_jump_next;
    logic              taken_next;
    logic [ADDR_W-1:0] target_next;
    logic              fire_next;

    logic              imm_form;
    logic [DATA_W-1:0] lhs;
    logic [DATA_W-1:0] rhs;
    logic [4:0]        shamt;
    logic [ADDR_W-1:0] pc_plus_imm;
    logic [ADDR_W-1:0] pc_plus_4;
    logic [ADDR_W-1:0] jalr_target;
    logic              lt_signed;
    logic              lt_unsigned;
    logic              eq;

    // Tag 0 means "no ROB entry", so such ops never reach the bus.
    assign fire_next = port_if.in_rs_enable && (port_if.in_rs_dest != '0);

    assign imm_form    = (port_if.in_rs_type >= OP_ADDI) && (port_if.in_rs_type <= OP_SRAI);
    assign lhs         = port_if.in_rs_left_oprand;
    assign rhs         = imm_form ? port_if.in_rs_imm : port_if.in_rs_right_oprand;
    assign shamt       = rhs[4:0];
    assign pc_plus_imm = port_if.in_rs_pc + ADDR_W'(port_if.in_rs_imm);
    assign pc_plus_4   = port_if.in_rs_pc + ADDR_W'(4);
    assign jalr_target = ADDR_W'(lhs + port_if.in_rs_imm) & ~ADDR_W'(1);

    // Branch comparisons always use the two register operands.
    assign eq          = port_if.in_rs_left_oprand == port_if.in_rs_right_oprand;
    assign lt_signed   = $signed(lhs) < $signed(rhs);
    assign lt_unsigned = lhs < rhs;

    always_comb begin
        result_next  = '0;
        is_jump_next = 1'b0;
        taken_next   = 1'b0;
        target_next  = '0;
        case (port_if.in_rs_type)
            OP_LUI:   result_next = port_if.in_rs_imm;
            OP_AUIPC: result_next = DATA_W'(pc_plus_imm);
            OP_JAL: begin
                result_next  = DATA_W'(pc_plus_4);
                is_jump_next = 1'b1;
                taken_next   = 1'b1;
                target_next  = pc_plus_imm;
            end
            OP_JALR: begin
                result_next  = DATA_W'(pc_plus_4);
                is_jump_next = 1'b1;
                taken_next   = 1'b1;
                target_next  = jalr_target;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                is_jump_next = 1'b1;
                target_next  = pc_plus_imm;
                case (port_if.in_rs_type)
                    OP_BEQ:  taken_next = eq;
                    OP_BNE:  taken_next = !eq;
                    OP_BLT:  taken_next = lt_signed;
                    OP_BGE:  taken_next = !lt_signed;
                    OP_BLTU: taken_next = lt_unsigned;
                    default: taken_next = !lt_unsigned;
                endcase
            end
            OP_ADD, OP_ADDI:   result_next = lhs + rhs;
            OP_SUB:            result_next = lhs - rhs;
            OP_SLT, OP_SLTI:   result_next = {{(DATA_W-1){1'b0}}, lt_signed};
            OP_SLTU, OP_SLTIU: result_next = {{(DATA_W-1){1'b0}}, lt_unsigned};
            OP_XOR, OP_XORI:   result_next = lhs ^ rhs;
            OP_OR, OP_ORI:     result_next = lhs | rhs;
            OP_AND, OP_ANDI:   result_next = lhs & rhs;
            OP_SLL, OP_SLLI:   result_next = lhs << shamt;
            OP_SRL, OP_SRLI:   result_next = lhs >> shamt;
            OP_SRA, OP_SRAI:   result_next = DATA_W'($signed(lhs) >>> shamt);
            default: ;
        endcase
    end

    // Flush beats capture; payload registers only move on a real broadcast.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            enable_reg  <= 1'b0;
            reorder_reg <= '0;
            result_reg  <= '0;
            is_jump_reg <= 1'b0;
            taken_reg   <= 1'b0;
            target_reg  <= '0;
        end else if (in_rob_clear) begin
            enable_reg <= 1'b0;
        end else if (in_rdy) begin
            enable_reg  <= fire_next;
            reorder_reg <= port_if.in_rs_dest;
            if (fire_next) begin
                result_reg  <= result_next;
                is_jump_reg <= is_jump_next;
                taken_reg   <= taken_next;
                target_reg  <= target_next;
            end
        end
    end

    assign port_if.out_broadcast_enable    = enable_reg;
    assign port_if.out_broadcast_reorder   = reorder_reg;
    assign port_if.out_broadcast_result    = result_reg;
    assign port_if.out_broadcast_is_jump   = is_jump_reg;
    assign port_if.out_broadcast_taken     = taken_reg;
    assign port_if.out_broadcast_target_pc = target_reg;
endmodule

// File: tb/tb_alu_exec.sv
// Randomised scoreboard bench for alu_exec: stimulus pushes the expected CDB state
// per clock edge, a monitor pops and compares it just after that edge.
module tb_alu_exec;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ROB_W  = 4;
    localparam int OP_W   = 6;

    localparam logic [5:0] LUI = 1, AUIPC = 2, JAL = 3, JALR = 4;
    localparam logic [5:0] BEQ = 5, BNE = 6, BLT = 7, BGE = 8, BLTU = 9, BGEU = 10;
    localparam logic [5:0] LW = 13;
    localparam logic [5:0] ADDI = 19, SLTI = 20, SLTIU = 21, XORI = 22, ORI = 23, ANDI = 24;
    localparam logic [5:0] SLLI = 25, SRLI = 26, SRAI = 27;
    localparam logic [5:0] ADD = 28, SUB = 29, SLL = 30, SLT = 31, SLTU = 32, XOR_ = 33;
    localparam logic [5:0] SRL = 34, SRA = 35, OR_ = 36, AND_ = 37;

    typedef struct packed {
        logic        en;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        j;
        logic        t;
        logic [31:0] tgt;
    } cdb_t;

    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    logic in_rdy = 1'b0;
    logic in_rob_clear = 1'b0;

    alu_exec_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROB_W(ROB_W), .OP_W(OP_W)) bus ();

    alu_exec #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_rdy      (in_rdy),
        .in_rob_clear(in_rob_clear),
        .port_if     (bus)
    );

    always #5 in_clk = ~in_clk;

    cdb_t exp_q[$];
    cdb_t model;
    int   checks = 0;
    int   passes = 0;

    // Behavioural RV32I semantics straight from the instruction definitions.
    function automatic cdb_t ref_exec(input logic [5:0] op, input logic [31:0] pc,
                                      input logic [31:0] imm, input logic [31:0] a,
                                      input logic [31:0] b);
        cdb_t r;
        int   sh;
        r  = '0;
        sh = int'(b & 32'd31);
        case (op)
            LUI:   r.res = imm;
            AUIPC: r.res = pc + imm;
            JAL:   begin r.res = pc + 4; r.j = 1; r.t = 1; r.tgt = pc + imm; end
            JALR:  begin r.res = pc + 4; r.j = 1; r.t = 1; r.tgt = (a + imm) & 32'hFFFF_FFFE; end
            BEQ:   begin r.j = 1; r.t = (a == b);                   r.tgt = pc + imm; end
            BNE:   begin r.j = 1; r.t = (a != b);                   r.tgt = pc + imm; end
            BLT:   begin r.j = 1; r.t = ($signed(a) < $signed(b));  r.tgt = pc + imm; end
            BGE:   begin r.j = 1; r.t = ($signed(a) >= $signed(b)); r.tgt = pc + imm; end
            BLTU:  begin r.j = 1; r.t = (a < b);                    r.tgt = pc + imm; end
            BGEU:  begin r.j = 1; r.t = (a >= b);                   r.tgt = pc + imm; end
            ADD:   r.res = a + b;
            ADDI:  r.res = a + imm;
            SUB:   r.res = a - b;
            SLT:   r.res = ($signed(a) < $signed(b)) ? 1 : 0;
            SLTI:  r.res = ($signed(a) < $signed(imm)) ? 1 : 0;
            SLTU:  r.res = (a < b) ? 1 : 0;
            SLTIU: r.res = (a < imm) ? 1 : 0;
            XOR_:  r.res = a ^ b;
            XORI:  r.res = a ^ imm;
            OR_:   r.res = a | b;
            ORI:   r.res = a | imm;
            AND_:  r.res = a & b;
            ANDI:  r.res = a & imm;
            SLL:   r.res = a << sh;
            SLLI:  r.res = a << (imm & 31);
            SRL:   r.res = a >> sh;
            SRLI:  r.res = a >> (imm & 31);
            SRA:   r.res = $signed(a) >>> sh;
            SRAI:  r.res = $signed(a) >>> (imm & 31);
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_cdb(input string name, input cdb_t exp);
        cdb_t got;
        got.en  = bus.out_broadcast_enable;
        got.tag = bus.out_broadcast_reorder;
        got.res = bus.out_broadcast_result;
        got.j   = bus.out_broadcast_is_jump;
        got.t   = bus.out_broadcast_taken;
        got.tgt = bus.out_broadcast_target_pc;
        checks++;
        if (got !== exp)
            $display("FAIL %s @%0t: got en=%0b tag=%0d res=%h j=%0b t=%0b tgt=%h, expected en=%0b tag=%0d res=%h j=%0b t=%0b tgt=%h",
                     name, $time, got.en, got.tag, got.res, got.j, got.t, got.tgt,
                     exp.en, exp.tag, exp.res, exp.j, exp.t, exp.tgt);
        else
            passes++;
    endtask

    // Monitor: one expected record per clock edge once stimulus has started.
    initial begin
        cdb_t e;
        forever begin
            @(posedge in_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_cdb("cdb", e);
                $display("edge @%0t: en=%0b tag=%0d res=%h j=%0b t=%0b tgt=%h",
                         $time, e.en, e.tag, e.res, e.j, e.t, e.tgt);
            end
        end
    end

    task automatic drive(input logic en, input logic [5:0] op, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] dest, input logic rdy, input logic clr,
                         input logic rst_pulse);
        cdb_t r;
        @(negedge in_clk);
        if (rst_pulse) begin
            #1 in_rst = 1'b1;
            #1 check_cdb("async_rst", '0);
            #1 in_rst = 1'b0;
            model = '0;
        end
        bus.in_rs_enable       = en;
        bus.in_rs_type         = op;
        bus.in_rs_pc           = pc;
        bus.in_rs_imm          = imm;
        bus.in_rs_left_oprand  = a;
        bus.in_rs_right_oprand = b;
        bus.in_rs_dest         = dest;
        in_rdy                 = rdy;
        in_rob_clear           = clr;
        if (clr) begin
            model.en = 1'b0;
        end else if (rdy) begin
            model.en  = en && (dest != 0);
            model.tag = dest;
            if (model.en) begin
                r = ref_exec(op, pc, imm, a, b);
                model.res = r.res;
                model.j   = r.j;
                model.t   = r.t;
                model.tgt = r.tgt;
            end
        end
        exp_q.push_back(model);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] dest);
        drive(1'b1, op, pc, imm, a, b, dest, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        model = '0;
        bus.in_rs_enable = 1'b0;
        bus.in_rs_type = '0;
        bus.in_rs_pc = '0;
        bus.in_rs_imm = '0;
        bus.in_rs_left_oprand = '0;
        bus.in_rs_right_oprand = '0;
        bus.in_rs_dest = '0;

        repeat (3) @(posedge in_clk);
        #1 check_cdb("reset", '0);
        @(negedge in_clk);
        in_rst = 1'b0;

        issue(ADD, 32'h0, 32'h0, 32'd7, 32'd5, 4'd3);
        idle(1'b1);
        issue(SUB, 32'h0, 32'h0, 32'd0, 32'd1, 4'd1);
        issue(SRAI, 32'h0, 32'd33, 32'h8000_0000, 32'h0, 4'd2);
        issue(SLTU, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'd4);
        issue(SLT, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'd5);
        issue(BLT, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 4'd6);
        issue(BGEU, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 4'd7);
        issue(JALR, 32'h40, 32'd4, 32'h1003, 32'h0, 4'd8);
        issue(LUI, 32'h0, 32'hABCDE000, 32'h0, 32'h0, 4'd9);
        issue(AUIPC, 32'h1000, 32'h2000, 32'h0, 32'h0, 4'd10);
        issue(JAL, 32'h200, 32'hFFFF_FFF0, 32'h0, 32'h0, 4'd11);

        // Stall after a dispatch: the bus freezes, then the next ready edge drops enable.
        issue(ADD, 32'h0, 32'h0, 32'd100, 32'd23, 4'd12);
        drive(1'b1, SUB, 32'h0, 32'h0, 32'd9, 32'd9, 4'd13, 1'b0, 1'b0, 1'b0);
        drive(1'b1, XOR_, 32'h0, 32'h0, 32'd1, 32'd2, 4'd14, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Flush coincident with a dispatch, then a flush while stalled.
        issue(ADD, 32'h0, 32'h0, 32'd1, 32'd1, 4'd5);
        drive(1'b1, ADD, 32'h0, 32'h0, 32'd2, 32'd2, 4'd6, 1'b1, 1'b1, 1'b0);
        issue(ADD, 32'h0, 32'h0, 32'd3, 32'd3, 4'd7);
        drive(1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Async reset while a broadcast is up.
        issue(OR_, 32'h0, 32'h0, 32'hF0F0_0000, 32'h0000_0F0F, 4'd9);
        drive(1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b1);

        // Tag 0 never broadcasts; unknown opcodes still do, with zero payload.
        issue(ADD, 32'h0, 32'h0, 32'd4, 32'd4, 4'd0);
        issue(LW, 32'h80, 32'h10, 32'd4, 32'd4, 4'd10);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, imm;
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = $urandom;
            drive($urandom_range(0, 4) != 0, 6'($urandom_range(0, 40)), $urandom, imm, a, b,
                  4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 24) == 0, 1'b0);
        end
        idle(1'b1);

        @(posedge in_clk);
        #3;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending records, expected 0", exp_q.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
